// File: rtl/div_unsigned_mc_if.sv
// Stream bundle for div_unsigned_mc: {divisor, dividend} in, {remainder, quotient} out.
// The divider is the slave; whoever feeds it and drains it uses the master modport.
interface div_unsigned_mc_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 3,
    parameter int USER_W     = 1
);
    logic [DIVISOR_W+DIVIDEND_W-1:0] s_axis_data;
    logic [USER_W-1:0]               s_axis_user;
    logic                            s_axis_valid;
    logic                            s_axis_ready;
    logic [DIVISOR_W+DIVIDEND_W-1:0] m_axis_data;
    logic [USER_W-1:0]               m_axis_user;
    logic                            m_axis_err;
    logic                            m_axis_valid;
    logic                            m_axis_ready;

    modport slave (
        input  s_axis_data, s_axis_user, s_axis_valid, m_axis_ready,
        output s_axis_ready, m_axis_data, m_axis_user, m_axis_err, m_axis_valid
    );

    modport master (
        output s_axis_data, s_axis_user, s_axis_valid, m_axis_ready,
        input  s_axis_ready, m_axis_data, m_axis_user, m_axis_err, m_axis_valid
    );
endinterface

// File: rtl/div_unsigned_mc.sv
// Multi-cycle unsigned divider: fast path for divisor 0/1, restoring shift-subtract otherwise.
// Optional macro DIV_POW2_FAST_EN sends power-of-two divisors down the fast path as well.
module div_unsigned_mc #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 3,
    parameter int USER_W     = 1,
    parameter int SIM_DELAY  = 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               aclken,
    div_unsigned_mc_if.slave   bus
);
    localparam int WIDE_W = DIVIDEND_W + DIVISOR_W;
    localparam int IDX_W  = $clog2(DIVIDEND_W);

    // SIM_DELAY is accepted for drop-in compatibility; register updates carry no delay here.
    if (DIVIDEND_W < 2 || DIVISOR_W < 1 || DIVISOR_W > DIVIDEND_W || SIM_DELAY < 0) begin : g_bad_params
        $error("div_unsigned_mc: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CALC = 3'b010,
        ST_OUT  = 3'b100
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIVIDEND_W-1:0]   rem_q, rem_d;
    logic [DIVISOR_W-1:0]    dvsr_q, dvsr_d;
    logic [DIVIDEND_W-1:0]   quot_q, quot_d;
    logic [USER_W-1:0]       user_q, user_d;
    logic                    err_q, err_d;

    logic [DIVIDEND_W-1:0]   in_dividend_s;
    logic [DIVISOR_W-1:0]    in_divisor_s;
    logic                    accept_s;
    logic [WIDE_W-1:0]       shifted_s;
    logic [WIDE_W-1:0]       rem_wide_s;
    logic                    ge_s;
    logic [DIVIDEND_W-1:0]   rem_next_s;

`ifdef DIV_POW2_FAST_EN
    function automatic logic is_pow2_gt1(input logic [DIVISOR_W-1:0] v);
        return (v > DIVISOR_W'(1)) && ((v & (v - DIVISOR_W'(1))) == {DIVISOR_W{1'b0}});
    endfunction

    function automatic int pow2_log(input logic [DIVISOR_W-1:0] v);
        int r;
        r = 0;
        for (int b = 0; b < DIVISOR_W; b++) begin
            if (v[b]) begin
                r = b;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction
`endif

    assign in_dividend_s = bus.s_axis_data[DIVIDEND_W-1:0];
    assign in_divisor_s  = bus.s_axis_data[WIDE_W-1:DIVIDEND_W];
    assign accept_s      = aclken & bus.s_axis_valid & (state_q == ST_IDLE);

    // The compare runs at the full widened width so divisor<<i never overflows.
    assign shifted_s  = WIDE_W'(dvsr_q) << idx_q;
    assign rem_wide_s = WIDE_W'(rem_q);
    assign ge_s       = (rem_wide_s >= shifted_s);
    assign rem_next_s = ge_s ? (rem_q - DIVIDEND_W'(shifted_s)) : rem_q;

    // Next-state and datapath update for the IDLE/CALC/OUT controller.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        user_d  = user_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    dvsr_d = in_divisor_s;
                    user_d = bus.s_axis_user;
                    quot_d = {DIVIDEND_W{1'b0}};
                    err_d  = (in_divisor_s == {DIVISOR_W{1'b0}});
                    idx_d  = IDX_W'(DIVIDEND_W - 1);
                    rem_d  = in_dividend_s;
                    if (in_divisor_s == {DIVISOR_W{1'b0}}) begin
                        quot_d  = {DIVIDEND_W{1'b1}};
                        state_d = ST_OUT;
                    end else if (in_divisor_s == DIVISOR_W'(1)) begin
                        quot_d  = in_dividend_s;
                        rem_d   = {DIVIDEND_W{1'b0}};
                        state_d = ST_OUT;
`ifdef DIV_POW2_FAST_EN
                    end else if (is_pow2_gt1(in_divisor_s)) begin
                        quot_d  = in_dividend_s >> pow2_log(in_divisor_s);
                        rem_d   = in_dividend_s & ~({DIVIDEND_W{1'b1}} << pow2_log(in_divisor_s));
                        state_d = ST_OUT;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (aclken) begin
                    quot_d[idx_q] = ge_s;
                    rem_d         = rem_next_s;
                    if ((idx_q == {IDX_W{1'b0}}) || (rem_next_s == {DIVIDEND_W{1'b0}})) begin
                        state_d = ST_OUT;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_OUT: begin
                if (aclken && bus.m_axis_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; aclken low freezes everything.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            rem_q   <= {DIVIDEND_W{1'b0}};
            dvsr_q  <= {DIVISOR_W{1'b0}};
            quot_q  <= {DIVIDEND_W{1'b0}};
            user_q  <= {USER_W{1'b0}};
            err_q   <= 1'b0;
        end else if (aclken) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            user_q  <= user_d;
            err_q   <= err_d;
        end else begin
            state_q <= state_q;
            idx_q   <= idx_q;
            rem_q   <= rem_q;
            dvsr_q  <= dvsr_q;
            quot_q  <= quot_q;
            user_q  <= user_q;
            err_q   <= err_q;
        end
    end

    assign bus.s_axis_ready = aresetn & aclken & (state_q == ST_IDLE);
    assign bus.m_axis_valid = aresetn & aclken & (state_q == ST_OUT);
    assign bus.m_axis_data  = {rem_q[DIVISOR_W-1:0], quot_q};
    assign bus.m_axis_user  = user_q;
    assign bus.m_axis_err   = err_q;
endmodule

// File: tb/tb_div_unsigned_mc.sv
// Directed-vector bench for div_unsigned_mc (16-bit dividend, 3-bit divisor, 1-bit user).
module tb_div_unsigned_mc;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic aclken  = 1'b1;
    int   n_checks = 0;
    int   n_errs   = 0;

`ifdef DIV_POW2_FAST_EN
    localparam int LAT_POW2 = 1;
`else
    localparam int LAT_POW2 = 17;
`endif

    always #5 aclk = ~aclk;

    div_unsigned_mc_if #(.DIVIDEND_W(16), .DIVISOR_W(3), .USER_W(1)) bus ();

    div_unsigned_mc #(.DIVIDEND_W(16), .DIVISOR_W(3), .USER_W(1), .SIM_DELAY(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .aclken  (aclken),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, wait for the result, optionally stall/hold, then drain.
    task automatic do_div(input string tag, input logic [15:0] dd, input logic [2:0] dv,
                          input logic u, input logic [15:0] eq, input logic [2:0] er,
                          input logic ee, input int elat, input int hold, input int stall_at);
        int lat;
        bit stalled;
        stalled = 1'b0;
        check_eq({tag, "_srdy"}, 32'(bus.s_axis_ready), 32'd1);
        bus.s_axis_data  = {dv, dd};
        bus.s_axis_user  = u;
        bus.s_axis_valid = 1'b1;
        @(posedge aclk); #1;
        bus.s_axis_valid = 1'b0;
        bus.s_axis_data  = 19'h7FFFF;
        bus.s_axis_user  = ~u;
        lat = 1;
        while (!bus.m_axis_valid && lat < 40) begin
            if (lat == stall_at && !stalled) begin
                stalled = 1'b1;
                aclken  = 1'b0;
                repeat (3) begin
                    @(posedge aclk); #1;
                    check_eq({tag, "_stall_vld"}, 32'(bus.m_axis_valid), 32'd0);
                    check_eq({tag, "_stall_rdy"}, 32'(bus.s_axis_ready), 32'd0);
                end
                aclken = 1'b1;
            end
            @(posedge aclk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
        check_eq({tag, "_q"},   32'(bus.m_axis_data[15:0]),  32'(eq));
        check_eq({tag, "_r"},   32'(bus.m_axis_data[18:16]), 32'(er));
        check_eq({tag, "_err"}, 32'(bus.m_axis_err),  32'(ee));
        check_eq({tag, "_usr"}, 32'(bus.m_axis_user), 32'(u));
        repeat (hold) begin
            @(posedge aclk); #1;
            check_eq({tag, "_hold_vld"}, 32'(bus.m_axis_valid), 32'd1);
            check_eq({tag, "_hold_rdy"}, 32'(bus.s_axis_ready), 32'd0);
            check_eq({tag, "_hold_d"},   32'(bus.m_axis_data), 32'({er, eq}));
            check_eq({tag, "_hold_usr"}, 32'(bus.m_axis_user), 32'(u));
            check_eq({tag, "_hold_err"}, 32'(bus.m_axis_err),  32'(ee));
        end
        bus.m_axis_ready = 1'b1;
        @(posedge aclk); #1;
        bus.m_axis_ready = 1'b0;
        check_eq({tag, "_done_vld"}, 32'(bus.m_axis_valid), 32'd0);
    endtask

    initial begin
        bus.s_axis_data  = '0;
        bus.s_axis_user  = 1'b0;
        bus.s_axis_valid = 1'b0;
        bus.m_axis_ready = 1'b0;
        #1;
        check_eq("rst_srdy", 32'(bus.s_axis_ready), 32'd0);
        check_eq("rst_mvld", 32'(bus.m_axis_valid), 32'd0);
        check_eq("rst_data", 32'(bus.m_axis_data),  32'd0);
        check_eq("rst_user", 32'(bus.m_axis_user),  32'd0);
        check_eq("rst_err",  32'(bus.m_axis_err),   32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;

        do_div("d100_7",   16'd100,   3'd7, 1'b1, 16'd14,     3'd2, 1'b0, 17, 0, -1);
        do_div("d56_7",    16'd56,    3'd7, 1'b0, 16'd8,      3'd0, 1'b0, 14, 0, -1);
        do_div("dffff_3",  16'hFFFF,  3'd3, 1'b1, 16'h5555,   3'd0, 1'b0, 17, 0, -1);
        do_div("d1234_0",  16'd1234,  3'd0, 1'b0, 16'hFFFF,   3'd2, 1'b1, 1,  0, -1);
        do_div("dabcd_4",  16'hABCD,  3'd4, 1'b1, 16'h2AF3,   3'd1, 1'b0, LAT_POW2, 0, -1);
        do_div("d3_2",     16'd3,     3'd2, 1'b0, 16'd1,      3'd1, 1'b0, LAT_POW2, 0, -1);
        do_div("d1234h_1", 16'h1234,  3'd1, 1'b1, 16'h1234,   3'd0, 1'b0, 1,  0, -1);
        do_div("d0_5",     16'd0,     3'd5, 1'b0, 16'd0,      3'd0, 1'b0, 2,  0, -1);
        do_div("d5_6",     16'd5,     3'd6, 1'b1, 16'd0,      3'd5, 1'b0, 17, 0, -1);
        do_div("d7_7",     16'd7,     3'd7, 1'b0, 16'd1,      3'd0, 1'b0, 17, 0, -1);
        do_div("dffff_7",  16'hFFFF,  3'd7, 1'b1, 16'h2492,   3'd1, 1'b0, 17, 0, -1);
        do_div("hold",     16'd100,   3'd7, 1'b1, 16'd14,     3'd2, 1'b0, 17, 5, -1);
        do_div("stall",    16'd100,   3'd7, 1'b0, 16'd14,     3'd2, 1'b0, 17, 0, 4);

        // Reset in the middle of a CALC run discards the result.
        bus.s_axis_data  = {3'd7, 16'd100};
        bus.s_axis_user  = 1'b1;
        bus.s_axis_valid = 1'b1;
        @(posedge aclk); #1;
        bus.s_axis_valid = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        check_eq("midrst_pre_vld", 32'(bus.m_axis_valid), 32'd0);
        aresetn = 1'b0;
        #1;
        check_eq("midrst_srdy", 32'(bus.s_axis_ready), 32'd0);
        check_eq("midrst_data", 32'(bus.m_axis_data),  32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        #1;
        check_eq("postrst_srdy", 32'(bus.s_axis_ready), 32'd1);
        check_eq("postrst_mvld", 32'(bus.m_axis_valid), 32'd0);
        repeat (20) @(posedge aclk);
        #1;
        check_eq("postrst_idle_vld", 32'(bus.m_axis_valid), 32'd0);
        do_div("after_rst", 16'd56, 3'd7, 1'b1, 16'd8, 3'd0, 1'b0, 14, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
